main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameter: ALU_CTRL_W, default 2, width of alu_control.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: op  input  2  instruction class from IR: 00 data-proc, 01 memory, 10 branch, 11 undefined.
REQ-005 Port: funct  input  6  IR[25:20]: [5]=I, [4:1]=cmd, [0]=S for data-proc, or L for memory.
REQ-006 Port: cond  input  4  IR[31:28] condition field.
REQ-007 Port: alu_flags  input  4  NZCV from ALU, current cycle.
REQ-008 Ports, all outputs, 1 bit each: pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a.
REQ-009 Ports, all outputs, 2 bits each: alu_src_b, result_src, imm_src; plus alu_control (ALU_CTRL_W bits).
REQ-010 Port: state_dbg  output  4  current state encoding.

Function
REQ-011 Moore FSM; states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
REQ-012 Transitions: FETCH->DECODE unconditionally.
REQ-013 From DECODE: op=00 -> EXECI if funct[5], else EXECR; op=01 -> MEMADR; op=10 -> BRANCH; op=11 -> FETCH.
REQ-014 From MEMADR: funct[0]=1 -> MEMRD, else MEMWR.
REQ-015 Other chains: MEMRD->MEMWB->FETCH; MEMWR->FETCH; EXECR/EXECI->ALUWB->FETCH; BRANCH->FETCH.
REQ-016 Undecoded encodings 10-15 return to FETCH next cycle, with all write enables 0.
REQ-017 Latency: LDR 5 cycles, STR 4, data-proc 4, branch 3, undefined op 2.
REQ-018 FETCH: ir_write=1, pc_write=1, adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10, ALU add.
REQ-019 DECODE: alu_src_a=1, alu_src_b=10, result_src=10, ALU add; no write enables.
REQ-020 MEMADR: alu_src_a=0, alu_src_b=01, ALU add.
REQ-021 MEMRD: adr_src=1, result_src=00.
REQ-022 MEMWB: result_src=01, reg_write=1.
REQ-023 MEMWR: adr_src=1, result_src=00, mem_write=1.
REQ-024 EXECR: alu_src_a=0, alu_src_b=00. EXECI: alu_src_a=0, alu_src_b=01.
REQ-025 ALUWB: result_src=00, reg_write=1.
REQ-026 BRANCH: alu_src_a=0, alu_src_b=01, result_src=10, pc_write=1.
REQ-027 Unlisted outputs are 0 in every state.
REQ-028 imm_src = op when op is 00, 01 or 10, and 00 when op=11, in all states; this selects 8-bit zero-extend, 12-bit zero-extend, or 24-bit x4 respectively.
REQ-029 alu_control outside EXECR/EXECI = 00 (add).
REQ-030 alu_control in EXECR/EXECI, from cmd: 0100 -> 00 add; 0010 -> 01 sub; 0000 -> 10 and; 1100 -> 11 orr; any other cmd -> 00.
REQ-031 op, funct and cond are sampled only in DECODE and later states; their value during FETCH is ignored.

Reset
REQ-032 rst_n low: state forced to FETCH immediately, regardless of clock, including mid-instruction.
REQ-033 While rst_n is low: pc_write, ir_write, reg_write and mem_write are 0, the flags register is 0000, and state_dbg=0.
REQ-034 First rising edge after rst_n rises executes FETCH, then moves to DECODE.

Configuration
REQ-035 Macro MAIN_FSM_COND_EN defined: a 4-bit NZCV flags register is present.
REQ-036 With the macro, the flags register loads alu_flags at the end of EXECR/EXECI when funct[0]=1 and cond passes.
REQ-037 With the macro, cond is evaluated against the stored flags: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 fails.
REQ-038 With the macro, a failing cond forces reg_write, mem_write and BRANCH pc_write to 0; FETCH pc_write is unaffected and the state sequence is unchanged.
REQ-039 Macro undefined: no flags register; cond and alu_flags are ignored; every instruction executes.

Verification
REQ-040 Reset mid-MEMRD (state_dbg=3), rst_n low -> state_dbg=0 with no clock edge; all enables 0.
REQ-041 op=01, funct=000001 -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB; imm_src=01.
REQ-042 op=01, funct=000000 -> states 0,1,2,5,0; mem_write=1 for exactly one cycle.
REQ-043 op=00, funct=100101 -> states 0,1,7,8,0; alu_control=01 in EXECI; imm_src=00.
REQ-044 op=10 -> states 0,1,9,0; pc_write=1 in BRANCH; imm_src=10. op=11 -> states 0,1,0.
REQ-045 MAIN_FSM_COND_EN: SUBS with alu_flags=0100, then op=10 with cond=0001 (NE) -> pc_write=0 in BRANCH; same case with cond=0000 (EQ) -> pc_write=1.

Source files
------------

// File: rtl/main_fsm.sv
// Multi-cycle processor main control FSM (Moore): sequences fetch, decode, memory, ALU and branch steps.
// Optional MAIN_FSM_COND_EN adds an NZCV flags register and conditional execution.
module main_fsm #(
    parameter int ALU_CTRL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            op,
    input  logic [5:0]            funct,
    input  logic [3:0]            cond,
    input  logic [3:0]            alu_flags,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [1:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [3:0]            state_dbg
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   cond_pass_s;

`ifdef MAIN_FSM_COND_EN
    logic [3:0] flags_r;

    // Evaluate a condition field against stored NZCV flags
    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'b0000: cond_check = z;
            4'b0001: cond_check = ~z;
            4'b0010: cond_check = cy;
            4'b0011: cond_check = ~cy;
            4'b0100: cond_check = n;
            4'b0101: cond_check = ~n;
            4'b0110: cond_check = v;
            4'b0111: cond_check = ~v;
            4'b1000: cond_check = cy & ~z;
            4'b1001: cond_check = ~cy | z;
            4'b1010: cond_check = (n == v);
            4'b1011: cond_check = (n != v);
            4'b1100: cond_check = ~z & (n == v);
            4'b1101: cond_check = z | (n != v);
            4'b1110: cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

    assign cond_pass_s = cond_check(cond, flags_r);

    // Flags capture at the end of a flag-setting, condition-passing ALU execute step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= 4'b0000;
        end else if ((state_r == EXECR || state_r == EXECI) && funct[0] && cond_pass_s) begin
            flags_r <= alu_flags;
        end else begin
            flags_r <= flags_r;
        end
    end
`else
    logic unused_s;
    assign unused_s    = ^{cond, alu_flags};
    assign cond_pass_s = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        next_state_s = FETCH;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        mem_write    = 1'b0;
        adr_src      = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        result_src   = 2'b00;
        alu_control  = ALU_CTRL_W'(2'b00);
        case (state_r)
            FETCH: begin
                next_state_s = DECODE;
                ir_write     = 1'b1;
                pc_write     = 1'b1;
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b00:   next_state_s = funct[5] ? EXECI : EXECR;
                    2'b01:   next_state_s = MEMADR;
                    2'b10:   next_state_s = BRANCH;
                    default: next_state_s = FETCH;
                endcase
            end
            MEMADR: begin
                next_state_s = funct[0] ? MEMRD : MEMWR;
                alu_src_b    = 2'b01;
            end
            MEMRD: begin
                next_state_s = MEMWB;
                adr_src      = 1'b1;
            end
            MEMWB: begin
                next_state_s = FETCH;
                result_src   = 2'b01;
                reg_write    = cond_pass_s;
            end
            MEMWR: begin
                next_state_s = FETCH;
                adr_src      = 1'b1;
                mem_write    = cond_pass_s;
            end
            EXECR, EXECI: begin
                next_state_s = ALUWB;
                alu_src_b    = (state_r == EXECI) ? 2'b01 : 2'b00;
                case (funct[4:1])
                    4'b0100: alu_control = ALU_CTRL_W'(2'b00);
                    4'b0010: alu_control = ALU_CTRL_W'(2'b01);
                    4'b0000: alu_control = ALU_CTRL_W'(2'b10);
                    4'b1100: alu_control = ALU_CTRL_W'(2'b11);
                    default: alu_control = ALU_CTRL_W'(2'b00);
                endcase
            end
            ALUWB: begin
                next_state_s = FETCH;
                reg_write    = cond_pass_s;
            end
            BRANCH: begin
                next_state_s = FETCH;
                alu_src_b    = 2'b01;
                result_src   = 2'b10;
                pc_write     = cond_pass_s;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
        // Reset holds the FSM in FETCH, but no write may fire while it is asserted
        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end else begin
            pc_write  = pc_write;
            ir_write  = ir_write;
            reg_write = reg_write;
            mem_write = mem_write;
        end
    end

    // Immediate format follows the instruction class in every state
    always_comb begin
        if (op == 2'b11) begin
            imm_src = 2'b00;
        end else begin
            imm_src = op;
        end
    end

    assign state_dbg = state_r;

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: instruction-level model of state sequences and control outputs.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic       pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, imm_src, alu_control;
    logic [3:0] state_dbg;

    main_fsm #(.ALU_CTRL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .cond(cond), .alu_flags(alu_flags),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .imm_src(imm_src), .alu_control(alu_control), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

`ifdef MAIN_FSM_COND_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    // Per-state control vector {pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a, alu_src_b, result_src}
    localparam logic [9:0] OUT_TAB [0:9] = '{
        10'b1100011010,  // FETCH
        10'b0000011010,  // DECODE
        10'b0000000100,  // MEMADR
        10'b0000100000,  // MEMRD
        10'b0010000001,  // MEMWB
        10'b0001100000,  // MEMWR
        10'b0000000000,  // EXECR
        10'b0000000100,  // EXECI
        10'b0010000000,  // ALUWB
        10'b1000000110   // BRANCH
    };

    int tests = 0;
    int fails = 0;

    bit         chk_en = 1'b0;
    logic [3:0] exp_state;
    logic [9:0] exp_vec;
    logic [1:0] exp_alu, exp_imm;
    logic [3:0] model_flags;
    int         cyc_cnt = 0, rw_cnt = 0, mw_cnt = 0, br_pcw = 0;
    logic [1:0] exec_alu = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        if (!COND_EN) return 1'b1;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'b1111) return 1'b0;
        if (c == 4'b1110) return 1'b1;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [1:0] model_alu(input logic [5:0] f, input int st);
        if (st != 6 && st != 7) return 2'b00;
        case (f[4:1])
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Compare DUT against the model once per cycle, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("state_dbg", {28'd0, state_dbg}, {28'd0, exp_state});
            check("ctrl_vec", {22'd0, pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
                               alu_src_b, result_src}, {22'd0, exp_vec});
            check("alu_control", {30'd0, alu_control}, {30'd0, exp_alu});
            check("imm_src", {30'd0, imm_src}, {30'd0, exp_imm});
            cyc_cnt++;
            rw_cnt += int'(reg_write);
            mw_cnt += int'(mem_write);
            if (state_dbg == 4'd9) br_pcw += int'(pc_write);
            if (state_dbg == 4'd6 || state_dbg == 4'd7) exec_alu = alu_control;
        end
    end

    // Run one instruction from FETCH; abort_at >= 0 asserts reset during that step instead
    task automatic run_instr(input logic [1:0] op_i, input logic [5:0] funct_i, input logic [3:0] cond_i,
                             input logic [3:0] flags_i, input int abort_at);
        int seq[$];
        bit pass;
        logic [9:0] v;
        seq.push_back(0);
        seq.push_back(1);
        case (op_i)
            2'b00: begin seq.push_back(funct_i[5] ? 7 : 6); seq.push_back(8); end
            2'b01: begin
                seq.push_back(2);
                if (funct_i[0]) begin seq.push_back(3); seq.push_back(4); end
                else seq.push_back(5);
            end
            2'b10: seq.push_back(9);
            default: ;
        endcase
        op = op_i; funct = funct_i; cond = cond_i; alu_flags = flags_i;
        foreach (seq[i]) begin
            pass = model_pass(cond_i, model_flags);
            v = OUT_TAB[seq[i]];
            if (!pass) begin
                v[7] = 1'b0;
                v[6] = 1'b0;
                if (seq[i] == 9) v[9] = 1'b0;
            end
            exp_state = 4'(seq[i]);
            exp_vec   = v;
            exp_alu   = model_alu(funct_i, seq[i]);
            exp_imm   = (op_i == 2'b11) ? 2'b00 : op_i;
            chk_en    = 1'b1;
            if (i == abort_at) begin
                @(negedge clk);
                #1;
                chk_en = 1'b0;
                rst_n  = 1'b0;
                #1;
                check("rst_async_state", {28'd0, state_dbg}, 32'd0);
                check("rst_async_enables", {28'd0, pc_write, ir_write, reg_write, mem_write}, 32'd0);
                @(posedge clk);
                #1;
                check("rst_hold_state", {28'd0, state_dbg}, 32'd0);
                rst_n = 1'b1;
                model_flags = 4'b0000;
                return;
            end
            @(posedge clk);
            if ((seq[i] == 6 || seq[i] == 7) && funct_i[0] && pass) model_flags = flags_i;
            #1;
        end
    endtask

    task automatic run_pin(input string name, input logic [1:0] op_i, input logic [5:0] funct_i,
                           input logic [3:0] cond_i, input logic [3:0] flags_i,
                           input int e_cyc, input int e_rw, input int e_mw, input int e_br);
        int c0, r0, m0, b0;
        c0 = cyc_cnt; r0 = rw_cnt; m0 = mw_cnt; b0 = br_pcw;
        run_instr(op_i, funct_i, cond_i, flags_i, -1);
        check({name, "_latency"}, cyc_cnt - c0, e_cyc);
        check({name, "_reg_write_cycles"}, rw_cnt - r0, e_rw);
        check({name, "_mem_write_cycles"}, mw_cnt - m0, e_mw);
        check({name, "_branch_pc_write"}, br_pcw - b0, e_br);
    endtask

    initial begin
        rst_n = 1'b0;
        op = 2'b00; funct = 6'd0; cond = 4'd0; alu_flags = 4'd0;
        model_flags = 4'b0000;
        #12;
        check("reset_state", {28'd0, state_dbg}, 32'd0);
        check("reset_enables", {28'd0, pc_write, ir_write, reg_write, mem_write}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_pin("ldr", 2'b01, 6'b000001, 4'b1110, 4'b0000, 5, 1, 0, 0);
        run_pin("str", 2'b01, 6'b000000, 4'b1110, 4'b0000, 4, 0, 1, 0);
        run_pin("subs_imm", 2'b00, 6'b100101, 4'b1110, 4'b0100, 4, 1, 0, 0);
        check("subs_alu_control", {30'd0, exec_alu}, 32'd1);
        run_pin("b_ne", 2'b10, 6'b000000, 4'b0001, 4'b0000, 3, 0, 0, COND_EN ? 0 : 1);
        run_pin("b_eq", 2'b10, 6'b000000, 4'b0000, 4'b0000, 3, 0, 0, 1);
        run_pin("undef", 2'b11, 6'b111111, 4'b1110, 4'b0000, 2, 0, 0, 0);
        run_pin("orr_reg", 2'b00, 6'b011000, 4'b1110, 4'b0000, 4, 1, 0, 0);
        check("orr_alu_control", {30'd0, exec_alu}, 32'd3);
        run_pin("and_reg", 2'b00, 6'b000000, 4'b1110, 4'b0000, 4, 1, 0, 0);
        check("and_alu_control", {30'd0, exec_alu}, 32'd2);
        run_pin("add_reg", 2'b00, 6'b001000, 4'b1110, 4'b0000, 4, 1, 0, 0);
        run_pin("other_cmd", 2'b00, 6'b010110, 4'b1110, 4'b0000, 4, 1, 0, 0);
        check("other_alu_control", {30'd0, exec_alu}, 32'd0);
        run_pin("ldr_nv", 2'b01, 6'b000001, 4'b1111, 4'b0000, 5, COND_EN ? 0 : 1, 0, 0);
        run_pin("str_gt", 2'b01, 6'b000000, 4'b1100, 4'b0000, 4, 0, COND_EN ? 0 : 1, 0);

        // Reset in the middle of a load, while in MEMRD
        run_instr(2'b01, 6'b000001, 4'b1110, 4'b0000, 3);
        run_pin("b_eq_after_rst", 2'b10, 6'b000000, 4'b0000, 4'b0000, 3, 0, 0, COND_EN ? 0 : 1);
        run_pin("b_al", 2'b10, 6'b000000, 4'b1110, 4'b0000, 3, 0, 0, 1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
